tx_flow_scheduler: RTL and testbench
====================================

// Module: tx_flow_scheduler
// PURPOSE
//  Batch-aware round-robin scheduler for the CCI-P TX flow FIFOs. It sits between the flow FIFOs and the
//  request-queue pop path. It watches per-flow occupancy and picks one eligible flow (occupancy >= batch size).
//  It then drives exactly batch-size consecutive pop strobes to that flow, gated by CCI-P c1 almost-full.
//  This replaces the linear flow scan with a fair, flow-control-aware one.
// PARAMETERS
//  NIC_ID            0  NIC instance id, used only in $display messages
//  LMAX_NUM_OF_FLOWS 1  log2 of the max flow count; MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS
//  LTX_FIFO_DEPTH    3  width of each per-flow occupancy count
//  GAP_CYCLES        2  idle cycles after each batch, so occupancy counts reflect the pops; range 1..7
// PORTS
//  clk               in  1                  clock
//  reset             in  1                  synchronous, active-high
//  start             in  1                  scheduling enable
//  number_of_flows   in  LMAX_NUM_OF_FLOWS  index of the highest active flow (active flows 0..number_of_flows)
//  l_tx_batch_size   in  LMAX_CCIP_BATCH    log2 of the batch size: 0->1, 1->2, 2->4; 3 is clamped to 4
//  c1_almost_full    in  1                  sRx_c1TxAlmFull
//  ff_dw_in          in  MAX_TX_FLOWS*LTX_FIFO_DEPTH  per-flow occupancy; flow f uses bits [f*D +: D]
//  ff_pop_en_out     out MAX_TX_FLOWS       one-hot pop strobes, registered
//  sched_flow_id_out out LMAX_NUM_OF_FLOWS  flow currently/last granted, registered
//  batch_start_out   out 1                  1-cycle pulse on the first pop of each batch
//  busy_out          out 1                  high while in POP or GAP
//  grant_cnt_out     out MAX_TX_FLOWS*32    per-flow batch grant counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, rr_ptr 0, counters 0.
//  Reset mid-batch: pop strobes drop the next cycle and the partial batch is abandoned.
//  Batch size B = 1 << min(l_tx_batch_size, 2).
//  B and number_of_flows are latched when a grant is made; changes during POP/GAP take effect at the next grant.
//  FSM
//   IDLE: when start && !c1_almost_full, search flows rr_ptr, rr_ptr+1, ... (wrap after number_of_flows).
//     Pick the first flow with ff_dw >= B.
//     Hit in cycle t: state <= POP, sched_flow_id_out <= f, ff_pop_en_out[f] <= 1, batch_start_out <= 1.
//     This gives 1 cycle latency; the strobe is visible at t+1.
//     No hit, start=0, or almost_full=1: stay IDLE and output no pops.
//   POP: keep ff_pop_en_out[f] high for exactly B consecutive cycles (t+1 .. t+B), counted by pop_cnt.
//     After the last pop: state <= GAP, rr_ptr <= (f == number_of_flows) ? 0 : f+1.
//     c1_almost_full or start dropping during POP does NOT truncate the batch; multi-CL writes must stay contiguous.
//     Max B = 4 lines fits the CCI-P almost-full slack.
//   GAP: hold GAP_CYCLES cycles with no pops, then go to IDLE.
//  Flows above number_of_flows are never granted, regardless of occupancy.
//  rr_ptr > number_of_flows (after a shrink) is treated as 0.
//  At most one ff_pop_en_out bit is ever high. Strobes are never issued to a flow with ff_dw < B at grant time.
//  Fairness: with N flows continuously eligible, each flow gets exactly one batch per N grants.
// CONFIGURATION
//  TX_SCHED_STATS_EN
//   defined: grant_cnt_out[f] increments (32-bit, wraps) on each batch_start_out for flow f; cleared by reset.
//   undefined: grant_cnt_out is tied to 0 and no counter flops are built; all other behaviour is identical.
// STRUCTURE
//  nic_defs.vh: typedefs FlowId, TxBatch, TxSchedState (enum IDLE/POP/GAP); constant LMAX_CCIP_BATCH.
//  Sub-module rr_flow_picker (combinational): inputs = occupancy vector, rr_ptr, number_of_flows, B;
//   outputs = hit and flow id (rotated priority encoder).
//  The top level holds the FSM, counters and registered outputs.
// TESTING
//  1 flow, B=1, ff_dw[0]=3, start=1 -> a pop strobe every (1+GAP_CYCLES+1) cycles;
//    batch_start on each strobe; flow id 0.
//  4 flows, B=4, all ff_dw=7 -> grants in order 0,1,2,3,0; each is 4 contiguous pops; never two bits high at once.
//  B=2, ff_dw[1]=1, ff_dw[2]=2, rr_ptr=1 -> flow 2 granted, flow 1 skipped; next search starts at 3.
//  B=4, grant issued, almost_full asserted at the 2nd pop -> all 4 pops complete;
//    no new grant until almost_full clears.
//  number_of_flows=1, ff_dw[3]=7 -> flow 3 never popped;
//    reset asserted during the 2nd pop of a batch -> ff_pop_en_out=0 the next cycle and rr_ptr=0.
//  With TX_SCHED_STATS_EN: after 5 grants to flow 0 and 3 to flow 1 -> grant_cnt 5 and 3; without the macro, 0.

Source files
------------

// File: rtl/tx_flow_scheduler_pkg.sv
// Shared types and helpers for the TX flow scheduler.
package tx_flow_scheduler_pkg;

  localparam int LMAX_CCIP_BATCH = 2;

  typedef logic [2:0] tx_batch_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } tx_sched_state_t;

  // log2 batch size to line count; anything above 2 clamps to 4 lines.
  function automatic tx_batch_t batch_size(input logic [LMAX_CCIP_BATCH-1:0] l_batch);
    return (l_batch >= 2'd2) ? 3'd4 : ((l_batch == 2'd1) ? 3'd2 : 3'd1);
  endfunction

endpackage

// File: rtl/tx_flow_scheduler_if.sv
// Flow-FIFO side of the scheduler: occupancy in, pop strobes and status out.
interface tx_flow_scheduler_if #(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LTX_FIFO_DEPTH    = 3
);
  localparam int MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS;

  logic [MAX_TX_FLOWS*LTX_FIFO_DEPTH-1:0] ff_dw_in;
  logic [MAX_TX_FLOWS-1:0]                ff_pop_en_out;
  logic [LMAX_NUM_OF_FLOWS-1:0]           sched_flow_id_out;
  logic                                   batch_start_out;
  logic                                   busy_out;
  logic [MAX_TX_FLOWS*32-1:0]             grant_cnt_out;

  modport master (
    input  ff_dw_in,
    output ff_pop_en_out, sched_flow_id_out, batch_start_out, busy_out, grant_cnt_out
  );

  modport slave (
    output ff_dw_in,
    input  ff_pop_en_out, sched_flow_id_out, batch_start_out, busy_out, grant_cnt_out
  );
endinterface

// File: rtl/tx_flow_scheduler_rr_flow_picker.sv
// Combinational rotated priority encoder: first flow at or after rr_ptr
// (wrapping at number_of_flows) whose occupancy covers the batch.
module tx_flow_scheduler_rr_flow_picker
  import tx_flow_scheduler_pkg::*;
#(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LTX_FIFO_DEPTH    = 3
) (
  input  logic [(2**LMAX_NUM_OF_FLOWS)*LTX_FIFO_DEPTH-1:0] ff_dw,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                     rr_ptr,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                     number_of_flows,
  input  tx_batch_t                                        batch,
  output logic                                             hit,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                     flow_id
);
  localparam int N  = 2**LMAX_NUM_OF_FLOWS;
  localparam int FW = LMAX_NUM_OF_FLOWS;
  localparam int D  = LTX_FIFO_DEPTH;

  logic [N-1:0]  eligible;
  logic [FW-1:0] idx_sel;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elig
      assign eligible[gi] = (32'(ff_dw[gi*D +: D]) >= 32'(batch)) &&
                            (int'(gi) <= int'(number_of_flows));
    end
  endgenerate

  always_comb begin
    int base;
    int idx;
    hit     = 1'b0;
    flow_id = '0;
    idx_sel = '0;
    idx     = 0;
    // A stale pointer beyond the active range (after a shrink) restarts at 0.
    base = (int'(rr_ptr) > int'(number_of_flows)) ? 0 : int'(rr_ptr);
    for (int k = 0; k < N; k++) begin
      if (k <= int'(number_of_flows)) begin
        idx = base + k;
        if (idx > int'(number_of_flows)) idx = idx - int'(number_of_flows) - 1;
        idx_sel = FW'(idx);
        if (!hit && eligible[idx_sel]) begin
          hit     = 1'b1;
          flow_id = idx_sel;
        end
      end
    end
  end

endmodule

// File: rtl/tx_flow_scheduler.sv
// Batch-aware round-robin TX flow scheduler: grants one eligible flow and issues
// exactly one batch of contiguous pops. Optional grant counters: TX_SCHED_STATS_EN.
module tx_flow_scheduler
  import tx_flow_scheduler_pkg::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LTX_FIFO_DEPTH    = 3,
  parameter int GAP_CYCLES        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
  input  logic                         c1_almost_full,
  tx_flow_scheduler_if.master          sif
);
  localparam int MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int FW           = LMAX_NUM_OF_FLOWS;

  if (GAP_CYCLES < 1 || GAP_CYCLES > 7) begin : g_bad_gap
    $error("tx_flow_scheduler NIC %0d: GAP_CYCLES must be in 1..7", NIC_ID);
  end

  tx_sched_state_t         state_reg;
  logic [FW-1:0]           rr_ptr_reg;
  logic [FW-1:0]           flow_reg;
  logic [FW-1:0]           nof_reg;
  tx_batch_t               batch_reg;
  tx_batch_t               pop_cnt_reg;
  logic [2:0]              gap_cnt_reg;
  logic [MAX_TX_FLOWS-1:0] pop_en_reg;
  logic                    batch_start_reg;
  logic                    busy_reg;

  tx_batch_t     cur_batch;
  logic          pick_hit;
  logic [FW-1:0] pick_flow;

  assign cur_batch = batch_size(l_tx_batch_size);

  tx_flow_scheduler_rr_flow_picker #(
    .LMAX_NUM_OF_FLOWS (LMAX_NUM_OF_FLOWS),
    .LTX_FIFO_DEPTH    (LTX_FIFO_DEPTH)
  ) u_picker (
    .ff_dw           (sif.ff_dw_in),
    .rr_ptr          (rr_ptr_reg),
    .number_of_flows (number_of_flows),
    .batch           (cur_batch),
    .hit             (pick_hit),
    .flow_id         (pick_flow)
  );

  // Once a batch is granted it runs to completion: almost-full and start are
  // only consulted in IDLE so multi-line writes stay contiguous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      flow_reg        <= '0;
      nof_reg         <= '0;
      batch_reg       <= '0;
      pop_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      pop_en_reg      <= '0;
      batch_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      batch_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !c1_almost_full && pick_hit) begin
            state_reg       <= POP;
            busy_reg        <= 1'b1;
            flow_reg        <= pick_flow;
            nof_reg         <= number_of_flows;
            batch_reg       <= cur_batch;
            pop_cnt_reg     <= 3'd1;
            pop_en_reg      <= MAX_TX_FLOWS'(1) << pick_flow;
            batch_start_reg <= 1'b1;
          end
        end
        POP: begin
          if (pop_cnt_reg == batch_reg) begin
            state_reg   <= GAP;
            pop_en_reg  <= '0;
            gap_cnt_reg <= 3'd1;
            rr_ptr_reg  <= (flow_reg == nof_reg) ? '0 : flow_reg + FW'(1);
          end else begin
            pop_cnt_reg <= pop_cnt_reg + 3'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == 3'(GAP_CYCLES)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 3'd1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          pop_en_reg <= '0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign sif.ff_pop_en_out     = pop_en_reg;
  assign sif.sched_flow_id_out = flow_reg;
  assign sif.batch_start_out   = batch_start_reg;
  assign sif.busy_out          = busy_reg;

`ifdef TX_SCHED_STATS_EN
  generate
    for (genvar gi = 0; gi < MAX_TX_FLOWS; gi++) begin : g_stats
      logic [31:0] grant_cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          grant_cnt_reg <= '0;
        end else if (batch_start_reg && (flow_reg == FW'(gi))) begin
          grant_cnt_reg <= grant_cnt_reg + 32'd1;
        end
      end
      assign sif.grant_cnt_out[gi*32 +: 32] = grant_cnt_reg;
    end
  endgenerate
`else
  assign sif.grant_cnt_out = '0;
`endif

endmodule

// File: tb/tb_tx_flow_scheduler.sv
// Scoreboard bench for tx_flow_scheduler: 4 flows, 3-bit occupancy, GAP_CYCLES=2.
module tb_tx_flow_scheduler;
  import tx_flow_scheduler_pkg::*;

  localparam int LF  = 2;
  localparam int D   = 3;
  localparam int N   = 4;
  localparam int GAP = 2;

  logic                       clk   = 1'b0;
  logic                       reset = 1'b1;
  logic                       start = 1'b0;
  logic                       af    = 1'b0;
  logic [LF-1:0]              nof   = '0;
  logic [LMAX_CCIP_BATCH-1:0] lbs   = '0;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int c;
    int flow;
    bit bs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  tx_flow_scheduler_if #(.LMAX_NUM_OF_FLOWS(LF), .LTX_FIFO_DEPTH(D)) sif();

  tx_flow_scheduler #(
    .NIC_ID            (0),
    .LMAX_NUM_OF_FLOWS (LF),
    .LTX_FIFO_DEPTH    (D),
    .GAP_CYCLES        (GAP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .number_of_flows (nof),
    .l_tx_batch_size (lbs),
    .c1_almost_full  (af),
    .sif             (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [N*D-1:0] dw(input int d3, input int d2, input int d1, input int d0);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  task automatic push_batch(input int c, input int f, input int b);
    for (int j = 0; j < b; j++) exp_q.push_back('{c + j, f, (j == 0)});
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    af    = 1'b0;
    @(negedge clk);
    chk("rst_pop_en", 64'(sif.ff_pop_en_out), 64'd0);
    chk("rst_flow_id", 64'(sif.sched_flow_id_out), 64'd0);
    chk("rst_batch_start", 64'(sif.batch_start_out), 64'd0);
    chk("rst_busy", 64'(sif.busy_out), 64'd0);
    for (int f = 0; f < N; f++) chk("rst_grant_cnt", 64'(sif.grant_cnt_out[f*32 +: 32]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 64) begin
      @(negedge clk);
      i++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  // Monitor: every pop strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() != 0 && exp_q[0].c < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_pop: got no pop at cyc %0d, expected flow %0d", exp_q[0].c, exp_q[0].flow);
        void'(exp_q.pop_front());
      end
      if (sif.ff_pop_en_out != '0) begin
        chk("pop_onehot", 64'($countones(sif.ff_pop_en_out)), 64'd1);
        if (exp_q.size() == 0 || exp_q[0].c != cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop @cyc %0d: got pop 0x%0h, expected none", cyc, sif.ff_pop_en_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_vector", 64'(sif.ff_pop_en_out), 64'd1 << mon_e.flow);
          chk("sched_flow_id", 64'(sif.sched_flow_id_out), 64'(mon_e.flow));
          chk("batch_start", 64'(sif.batch_start_out), 64'(mon_e.bs));
          if (mon_e.bs) $display("batch: flow %0d granted, first pop at cyc %0d", mon_e.flow, cyc);
        end
      end else begin
        chk("idle_batch_start", 64'(sif.batch_start_out), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [31:0] e0, e1;
    sif.ff_dw_in = '0;
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    // 1 flow, B=1: a pop every 1+GAP+1 = 4 cycles; flows above 0 ignored.
    nof = 2'd0; lbs = 2'd0; sif.ff_dw_in = dw(7, 7, 7, 3);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 1); push_batch(s + 5, 0, 1); push_batch(s + 9, 0, 1);
    goto(s + 3); chk("busy_in_gap", 64'(sif.busy_out), 64'd1);
    goto(s + 4); chk("busy_in_idle", 64'(sif.busy_out), 64'd0);
    goto(s + 10); start = 1'b0;
    drain();

    // 4 flows, l=3 clamps to B=4: grants 0,1,2,3,0 every 4+GAP+1 = 7 cycles.
    do_reset();
    nof = 2'd3; lbs = 2'd3; sif.ff_dw_in = dw(7, 7, 7, 7);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 4);  push_batch(s + 8, 1, 4); push_batch(s + 15, 2, 4);
    push_batch(s + 22, 3, 4); push_batch(s + 29, 0, 4);
    goto(s + 33); start = 1'b0;
    drain();

    // B=2: flow 1 (occ 1) skipped, after flow 2 the search starts at 3.
    do_reset();
    nof = 2'd3; lbs = 2'd1; sif.ff_dw_in = dw(2, 2, 1, 2);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 2);  push_batch(s + 6, 2, 2);
    push_batch(s + 11, 3, 2); push_batch(s + 16, 0, 2);
    goto(s + 17); start = 1'b0;
    drain();

    // B=4: almost-full at the 2nd pop does not truncate; blocks grants until clear.
    do_reset();
    nof = 2'd1; lbs = 2'd2; sif.ff_dw_in = dw(0, 0, 7, 7);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 4); push_batch(s + 13, 1, 4);
    goto(s + 2);  af = 1'b1;
    goto(s + 12); af = 1'b0;
    goto(s + 14); start = 1'b0;
    drain();

    // nof=1: flows 2,3 never popped; reset during 2nd pop abandons the batch.
    do_reset();
    nof = 2'd1; lbs = 2'd2; sif.ff_dw_in = dw(7, 7, 0, 7);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 4); push_batch(s + 8, 0, 2);
    goto(s + 9);
    do_reset();
    chk("abandoned_batch_pending", 64'(exp_q.size()), 64'd0);
    nof = 2'd3; sif.ff_dw_in = dw(7, 7, 7, 7);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 4);
    goto(s + 2); start = 1'b0;
    drain();

    // Grant counters: 5 grants to flow 0, 3 to flow 1.
    do_reset();
    nof = 2'd0; lbs = 2'd0; sif.ff_dw_in = dw(0, 0, 7, 7);
    start = 1'b1; s = cyc;
    push_batch(s + 1, 0, 1);  push_batch(s + 5, 0, 1);
    push_batch(s + 9, 0, 1);  push_batch(s + 13, 1, 1);
    push_batch(s + 17, 0, 1); push_batch(s + 21, 1, 1);
    push_batch(s + 25, 0, 1); push_batch(s + 29, 1, 1);
    goto(s + 6);  nof = 2'd1;
    goto(s + 30); start = 1'b0;
    drain();
`ifdef TX_SCHED_STATS_EN
    e0 = 32'd5; e1 = 32'd3;
`else
    e0 = 32'd0; e1 = 32'd0;
`endif
    chk("grant_cnt_flow0", 64'(sif.grant_cnt_out[0 +: 32]), 64'(e0));
    chk("grant_cnt_flow1", 64'(sif.grant_cnt_out[32 +: 32]), 64'(e1));
    chk("grant_cnt_flow2", 64'(sif.grant_cnt_out[64 +: 32]), 64'd0);
    chk("grant_cnt_flow3", 64'(sif.grant_cnt_out[96 +: 32]), 64'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
